// File: rtl/switch_event_if.sv
// Signal bundle between the debounced switch source and the event detector.
interface switch_event_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   i_Switch;
    logic                   o_Press;
    logic                   o_Release;
    logic                   o_Long;
    logic                   o_Repeat;
    logic                   o_Held;
    logic [COUNT_WIDTH-1:0] o_Count;

    modport slave (
        input  i_Switch,
        output o_Press, o_Release, o_Long, o_Repeat, o_Held, o_Count
    );

    modport master (
        output i_Switch,
        input  o_Press, o_Release, o_Long, o_Repeat, o_Held, o_Count
    );
endinterface

// File: rtl/switch_event_detector.sv
// Turns a debounced switch level into press/release/long/repeat pulses
// and keeps a wrapping press counter. All outputs are registered.
module switch_event_detector #(
    parameter int LONG_LIMIT    = 12500000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic           i_Clk,
    input  logic           i_Rst_L,
    switch_event_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

    // Terminal counts: hold counter is zeroed on the event edge, so the
    // pulse fires when it has reached limit-1.
    localparam logic [23:0] LONG_LAST = 24'(LONG_LIMIT - 1);
    localparam logic [23:0] REP_LAST  = 24'(REPEAT_PERIOD - 1);

    state_t                 state_q, state_d;
    logic                   prev_q;
    logic [23:0]            hold_q, hold_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   long_q, long_d;
    logic                   rep_q, rep_d;
    logic                   held_q;
    logic                   rise, fall;

    assign rise = bus.i_Switch & ~prev_q;
    assign fall = ~bus.i_Switch & prev_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    count_d = count_q + 1'b1;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                // A fall takes priority over a coincident long-press.
                if (fall) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    hold_d  = '0;
                end else if (hold_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 24'd1;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    hold_d  = '0;
                end else if (hold_q == REP_LAST) begin
                    rep_d  = 1'b1;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            hold_q  <= '0;
            count_q <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= bus.i_Switch;
            hold_q  <= hold_d;
            count_q <= count_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= (state_d != IDLE);
        end
    end

    assign bus.o_Press   = press_q;
    assign bus.o_Release = rel_q;
    assign bus.o_Long    = long_q;
    assign bus.o_Repeat  = rep_q;
    assign bus.o_Held    = held_q;
    assign bus.o_Count   = count_q;
endmodule
